// File: rtl/ex_stage.sv
// Execute stage: EX pipeline register, one-hot ALU, data-SRAM request, HI/LO
// registers and a 32-step restoring divider for div/divu.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall_i,
    input  logic [158:0] id_to_ex_bus_i,
    output logic [75:0]  ex_to_mem_bus_o,
    output logic [37:0]  ex_to_rf_bus_o,
    output logic         data_sram_en_o,
    output logic [3:0]   data_sram_wen_o,
    output logic [31:0]  data_sram_addr_o,
    output logic [31:0]  data_sram_wdata_o,
    output logic         stallreq_for_ex_o
);
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    logic [158:0] bus_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else if (stall_i[2] == Stop && stall_i[3] == NoStop) begin
            bus_q <= '0;
        end else if (stall_i[2] == NoStop) begin
            bus_q <= id_to_ex_bus_i;
        end
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr,
            sel_rf_res, rdata1, rdata2} = bus_q;

    logic unused_inst;
    assign unused_inst = ^inst[25:16];

    logic is_special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_divu, div_op;
    assign is_special = inst[31:26] == 6'b000000;
    assign is_mfhi    = is_special && inst[5:0] == 6'b010000;
    assign is_mthi    = is_special && inst[5:0] == 6'b010001;
    assign is_mflo    = is_special && inst[5:0] == 6'b010010;
    assign is_mtlo    = is_special && inst[5:0] == 6'b010011;
    assign is_div     = is_special && inst[5:0] == 6'b011010;
    assign is_divu    = is_special && inst[5:0] == 6'b011011;
    assign div_op     = is_div || is_divu;

    logic [31:0] imm_sext, imm_zext, src1, src2;
    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'b0, inst[15:0]};

    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & imm_sext)
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & imm_zext);

    logic [4:0]  shamt;
    logic [31:0] sum_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
    logic [31:0] alu_res;

    assign shamt    = src1[4:0];
    assign sum_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sll_res  = src2 << shamt;
    assign srl_res  = src2 >> shamt;
    assign sra_res  = $signed(src2) >>> shamt;
    assign lui_res  = {src2[15:0], 16'b0};

    // alu_op is one-hot (or all zero for bubbles), so an AND-OR mux suffices
    always_comb begin
        alu_res = ({32{alu_op[11]}} & sum_res)
                | ({32{alu_op[10]}} & sub_res)
                | ({32{alu_op[9]}}  & slt_res)
                | ({32{alu_op[8]}}  & sltu_res)
                | ({32{alu_op[7]}}  & (src1 & src2))
                | ({32{alu_op[6]}}  & ~(src1 | src2))
                | ({32{alu_op[5]}}  & (src1 | src2))
                | ({32{alu_op[4]}}  & (src1 ^ src2))
                | ({32{alu_op[3]}}  & sll_res)
                | ({32{alu_op[2]}}  & srl_res)
                | ({32{alu_op[1]}}  & sra_res)
                | ({32{alu_op[0]}}  & lui_res);
    end

    div_state_e  state_q;
    logic [4:0]  count_q;
    logic [31:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
    logic        rs_neg_q, rt_neg_q, dz_q;

    logic        rs_neg, rt_neg;
    logic [31:0] rs_abs, rt_abs;
    assign rs_neg = is_div && rdata1[31];
    assign rt_neg = is_div && rdata2[31];
    assign rs_abs = rs_neg ? -rdata1 : rdata1;
    assign rt_abs = rt_neg ? -rdata2 : rdata2;

    logic [32:0] trial, trial_diff;
    logic        fits;
    assign trial      = {rem_q, quo_q[31]};
    assign trial_diff = trial - {1'b0, dvs_q};
    assign fits       = ~trial_diff[32];

    // With a zero divisor the remainder ends up equal to |rs|, so the sign
    // fix-up below already yields HI = rs; only LO needs the special case.
    logic [31:0] quo_fix, rem_fix;
    assign quo_fix = dz_q ? 32'hFFFF_FFFF : ((rs_neg_q ^ rt_neg_q) ? -quo_q : quo_q);
    assign rem_fix = rs_neg_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rs_neg_q <= 1'b0;
            rt_neg_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (stall_i[3] == NoStop) begin
                if (is_mthi) hi_q <= rdata1;
                if (is_mtlo) lo_q <= rdata1;
            end
            unique case (state_q)
                StIdle: begin
                    if (div_op) begin
                        state_q  <= StBusy;
                        count_q  <= '0;
                        rem_q    <= '0;
                        quo_q    <= rs_abs;
                        dvs_q    <= rt_abs;
                        rs_neg_q <= rs_neg;
                        rt_neg_q <= rt_neg;
                        dz_q     <= rdata2 == 32'd0;
                    end
                end
                StBusy: begin
                    rem_q   <= fits ? trial_diff[31:0] : trial[31:0];
                    quo_q   <= {quo_q[30:0], fits};
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) state_q <= StDone;
                end
                StDone: begin
                    if (stall_i[3] == NoStop) begin
                        state_q <= StIdle;
                        hi_q    <= rem_fix;
                        lo_q    <= quo_fix;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic        rf_we_out;
    logic [4:0]  rf_waddr_out;
    logic [31:0] ex_result;

    assign rf_we_out    = rf_we || is_mfhi || is_mflo;
    assign rf_waddr_out = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr;
    assign ex_result    = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    assign ex_to_mem_bus_o = {pc, ram_en, ram_wen, sel_rf_res, rf_we_out, rf_waddr_out,
                              ex_result};
    assign ex_to_rf_bus_o  = {rf_we_out, rf_waddr_out, ex_result};

    assign data_sram_en_o    = ram_en;
    assign data_sram_wen_o   = ram_wen;
    assign data_sram_addr_o  = alu_res;
    assign data_sram_wdata_o = rdata2;

    assign stallreq_for_ex_o = div_op && state_q != StDone;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected bus values are queued when a bundle is
// driven and checked once it sits in the EX register.
module tb_ex_stage;
    logic         clk;
    logic         rst;
    logic [5:0]   stall_i;
    logic [158:0] id_to_ex_bus_i;
    logic [75:0]  ex_to_mem_bus_o;
    logic [37:0]  ex_to_rf_bus_o;
    logic         data_sram_en_o;
    logic [3:0]   data_sram_wen_o;
    logic [31:0]  data_sram_addr_o;
    logic [31:0]  data_sram_wdata_o;
    logic         stallreq_for_ex_o;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .id_to_ex_bus_i    (id_to_ex_bus_i),
        .ex_to_mem_bus_o   (ex_to_mem_bus_o),
        .ex_to_rf_bus_o    (ex_to_rf_bus_o),
        .data_sram_en_o    (data_sram_en_o),
        .data_sram_wen_o   (data_sram_wen_o),
        .data_sram_addr_o  (data_sram_addr_o),
        .data_sram_wdata_o (data_sram_wdata_o),
        .stallreq_for_ex_o (stallreq_for_ex_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] OpAdd = 12'h800, OpSub = 12'h400, OpSlt = 12'h200;
    localparam logic [11:0] OpSltu = 12'h100, OpAnd = 12'h080, OpNor = 12'h040;
    localparam logic [11:0] OpOr = 12'h020, OpXor = 12'h010, OpSll = 12'h008;
    localparam logic [11:0] OpSrl = 12'h004, OpSra = 12'h002, OpLui = 12'h001;
    localparam logic [5:0]  StallNone = 6'b000000, StallDiv = 6'b001111;
    localparam logic [5:0]  StallBubble = 6'b000111;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    string       tag_q[$];
    logic [75:0] mem_q[$];
    logic [68:0] sram_q[$];

    function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd, sa,
                                           input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [158:0] bundle(input logic [31:0] pc, inst,
                                            input logic [11:0] op, input logic [2:0] s1,
                                            input logic [3:0] s2, input logic en,
                                            input logic [3:0] wen, input logic sel,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] rd1, rd2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, sel, rd1, rd2};
    endfunction

    function automatic logic [75:0] emem(input logic [31:0] pc, input logic en,
                                         input logic [3:0] wen, input logic sel,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] res);
        return {pc, en, wen, sel, we, wa, res};
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        string       t;
        logic [75:0] em;
        logic [68:0] es;
        t  = tag_q.pop_front();
        em = mem_q.pop_front();
        es = sram_q.pop_front();
        chk({t, "/mem"}, ex_to_mem_bus_o, em);
        chk({t, "/rf"}, {38'd0, ex_to_rf_bus_o}, {38'd0, em[37:0]});
        chk({t, "/sram"}, {7'd0, data_sram_en_o, data_sram_wen_o, data_sram_addr_o,
                           data_sram_wdata_o}, {7'd0, es});
    endtask

    task automatic issue(input string tag, input logic [158:0] b, input logic [5:0] st,
                         input logic [75:0] em, input logic [68:0] es);
        id_to_ex_bus_i = b;
        stall_i        = st;
        tag_q.push_back(tag);
        mem_q.push_back(em);
        sram_q.push_back(es);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic alu(input string tag, input logic [11:0] op, input logic [2:0] s1,
                       input logic [3:0] s2, input logic [31:0] inst, rd1, rd2, res);
        issue(tag, bundle(32'h0040_0100, inst, op, s1, s2, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7,
                          rd1, rd2), StallNone,
              emem(32'h0040_0100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, res),
              {1'b0, 4'h0, res, rd2});
    endtask

    task automatic mf(input string tag, input logic hi, input logic [4:0] rd,
                      input logic [31:0] exp);
        logic [31:0] inst;
        inst = r_inst(5'd0, 5'd0, rd, 5'd0, hi ? 6'b010000 : 6'b010010);
        issue(tag, bundle(32'h0040_0300, inst, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                          1'b0, 5'd0, 32'd0, 32'd0), StallNone,
              emem(32'h0040_0300, 1'b0, 4'h0, 1'b0, 1'b1, rd, exp), 69'd0);
    endtask

    task automatic mt(input string tag, input logic hi, input logic [31:0] val);
        logic [31:0] inst;
        inst = r_inst(5'd4, 5'd0, 5'd0, 5'd0, hi ? 6'b010001 : 6'b010011);
        issue(tag, bundle(32'h0040_0304, inst, 12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0,
                          1'b0, 5'd0, val, 32'd0), StallNone,
              emem(32'h0040_0304, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0), 69'd0);
    endtask

    task automatic load_div(input logic is_u, input logic [31:0] rs, rt);
        logic [31:0] inst;
        inst = r_inst(5'd1, 5'd2, 5'd0, 5'd0, is_u ? 6'b011011 : 6'b011010);
        id_to_ex_bus_i = bundle(32'h0040_0200, inst, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0,
                                1'b0, 1'b0, 5'd0, rs, rt);
        stall_i = StallNone;
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string tag, input logic is_u, input logic [31:0] rs, rt,
                           input int hold);
        int n;
        load_div(is_u, rs, rt);
        n = 0;
        while (stallreq_for_ex_o === 1'b1 && n < 100) begin
            stall_i = StallDiv;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "/stall_cycles"}, 76'(n), 76'd33);
        for (int i = 0; i < hold; i++) begin
            stall_i = StallDiv;
            @(posedge clk);
            #1;
            chk({tag, "/done_hold"}, {75'd0, stallreq_for_ex_o}, 76'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        stall_i        = StallNone;
        id_to_ex_bus_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/mem", ex_to_mem_bus_o, 76'd0);
        chk("reset/rf", {38'd0, ex_to_rf_bus_o}, 76'd0);
        chk("reset/sram", {7'd0, data_sram_en_o, data_sram_wen_o, data_sram_addr_o,
                           data_sram_wdata_o}, 76'd0);
        chk("reset/stallreq", {75'd0, stallreq_for_ex_o}, 76'd0);
        rst = 1'b0;

        issue("addiu", bundle(32'h0040_0000, i_inst(6'b001001, 5'd1, 5'd5, 16'h0001), OpAdd,
                              3'b001, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5,
                              32'h7FFF_FFFF, 32'd0), StallNone,
              emem(32'h0040_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000),
              {1'b0, 4'h0, 32'h8000_0000, 32'd0});
        issue("lui", bundle(32'h0040_0004, i_inst(6'b001111, 5'd0, 5'd6, 16'h1234), OpLui,
                            3'b000, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'd0, 32'd0),
              StallNone, emem(32'h0040_0004, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h1234_0000),
              {1'b0, 4'h0, 32'h1234_0000, 32'd0});
        issue("sw", bundle(32'h0040_0008, i_inst(6'b101011, 5'd2, 5'd3, 16'hFFFC), OpAdd,
                           3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_1000,
                           32'hAABB_CCDD), StallNone,
              emem(32'h0040_0008, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0FFC),
              {1'b1, 4'hF, 32'h0000_0FFC, 32'hAABB_CCDD});
        issue("lw", bundle(32'h0040_000C, i_inst(6'b100011, 5'd2, 5'd8, 16'h0010), OpAdd,
                           3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_1000,
                           32'd0), StallNone,
              emem(32'h0040_000C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_1010),
              {1'b1, 4'h0, 32'h0000_1010, 32'd0});

        alu("sub", OpSub, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b100010),
            32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("slt", OpSlt, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b101010),
            32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("sltu", OpSltu, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b101011),
            32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("and", OpAnd, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b100100),
            32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("nor", OpNor, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b100111),
            32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F);
        alu("or", OpOr, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b100101),
            32'hF0F0_F0F0, 32'h0F0F_0F00, 32'hFFFF_FFF0);
        alu("xor", OpXor, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b100110),
            32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu("sll", OpSll, 3'b100, 4'b0001, r_inst(5'd0, 5'd2, 5'd7, 5'd4, 6'b000000),
            32'd0, 32'h0000_000F, 32'h0000_00F0);
        alu("srl", OpSrl, 3'b100, 4'b0001, r_inst(5'd0, 5'd2, 5'd7, 5'd4, 6'b000010),
            32'd0, 32'h8000_0000, 32'h0800_0000);
        alu("sra", OpSra, 3'b100, 4'b0001, r_inst(5'd0, 5'd2, 5'd7, 5'd4, 6'b000011),
            32'd0, 32'h8000_0000, 32'hF800_0000);
        alu("sllv", OpSll, 3'b001, 4'b0001, r_inst(5'd1, 5'd2, 5'd7, 5'd0, 6'b000100),
            32'h0000_0024, 32'd1, 32'h0000_0010);
        alu("pc_plus8", OpAdd, 3'b010, 4'b0100, r_inst(5'd0, 5'd0, 5'd31, 5'd0, 6'b001001),
            32'd0, 32'd0, 32'h0040_0108);

        mt("mthi", 1'b1, 32'hCAFE_BABE);
        mf("mfhi_after_mthi", 1'b1, 5'd3, 32'hCAFE_BABE);
        mt("mtlo", 1'b0, 32'h1234_5678);
        mf("mflo_after_mtlo", 1'b0, 5'd4, 32'h1234_5678);

        issue("bubble_add", bundle(32'h0040_0400, r_inst(5'd1, 5'd2, 5'd9, 5'd0, 6'b100001),
                                   OpAdd, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9,
                                   32'd1, 32'd2), StallNone,
              emem(32'h0040_0400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd3),
              {1'b0, 4'h0, 32'd3, 32'd2});
        issue("bubble_clear", bundle(32'h0040_0404, r_inst(5'd4, 5'd0, 5'd0, 5'd0, 6'b010001),
                                     12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,
                                     32'hDEAD_BEEF, 32'd0), StallBubble, 76'd0, 69'd0);
        mf("bubble_hi_kept", 1'b1, 5'd3, 32'hCAFE_BABE);
        mf("bubble_lo_kept", 1'b0, 5'd4, 32'h1234_5678);

        run_div("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        mf("div_mflo", 1'b0, 5'd10, 32'hFFFF_FFFD);
        mf("div_mfhi", 1'b1, 5'd11, 32'hFFFF_FFFF);

        run_div("divu_by0", 1'b1, 32'd5, 32'd0, 3);
        mf("divu0_mflo", 1'b0, 5'd12, 32'hFFFF_FFFF);
        mf("divu0_mfhi", 1'b1, 5'd13, 32'h0000_0005);

        load_div(1'b0, 32'd100, 32'd3);
        chk("rst_busy/idle_stallreq", {75'd0, stallreq_for_ex_o}, 76'd1);
        repeat (11) begin
            stall_i = StallDiv;
            @(posedge clk);
            #1;
        end
        chk("rst_busy/busy_stallreq", {75'd0, stallreq_for_ex_o}, 76'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy/mem", ex_to_mem_bus_o, 76'd0);
        chk("rst_busy/rf", {38'd0, ex_to_rf_bus_o}, 76'd0);
        chk("rst_busy/sram", {7'd0, data_sram_en_o, data_sram_wen_o, data_sram_addr_o,
                              data_sram_wdata_o}, 76'd0);
        chk("rst_busy/stallreq", {75'd0, stallreq_for_ex_o}, 76'd0);
        rst = 1'b0;
        mf("rst_busy_mfhi", 1'b1, 5'd14, 32'd0);
        mf("rst_busy_mflo", 1'b0, 5'd15, 32'd0);

        run_div("divu_100_7", 1'b1, 32'd100, 32'd7, 0);
        mf("divu_mflo", 1'b0, 5'd16, 32'd14);
        mf("divu_mfhi", 1'b1, 5'd17, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It registers the decoded bundle from the decode stage and computes the ALU result and data-SRAM request. It also owns the HI/LO registers and a 32-iteration radix-2 divider for div/divu. It feeds the memory stage, and it returns an early forwarding bus to decode.

## Interface
- No parameters; widths fixed by the shared defines (`StallBus`=6, `Stop`=1, `NoStop`=0).
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- stall  in  6  global stall vector; bit 2 = ID/EX boundary, bit 3 = EX/MEM boundary.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
- ex_to_mem_bus  out  76  {pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}.
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, forwarding to decode.
- data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data SRAM request.
- stallreq_for_ex  out  1  divider busy; stall controller freezes stages 0-3.

## Operation
- Input register:
  - rst: clear.
  - Else if stall[2]=Stop and stall[3]=NoStop: clear (bubble).
  - Else if stall[2]=NoStop: load id_to_ex_bus.
  - Else: hold.
- src1 one-hot: [0] rdata1, [1] pc, [2] {27'b0, inst[10:6]}.
- src2 one-hot: [0] rdata2, [1] sign-ext imm, [2] 32'd8, [3] zero-ext imm.
- alu_op one-hot, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Add/sub wrap modulo 2^32; no overflow trap.
  - slt is signed, sltu unsigned; both give 0/1.
  - Shifts shift src2 by src1[4:0]; sra is arithmetic.
  - lui = {src2[15:0], 16'b0}.
- HI/LO ops, decoded from inst with opcode 0 and func 010000/010010/010001/010011:
  - mfhi/mflo: ex_result = HI/LO, rf_we forced 1, rf_waddr = inst[15:11].
  - mthi/mtlo: HI/LO <= rdata1 on the edge where stall[3]=NoStop.
- data_sram_en = ram_en, data_sram_wen = ram_wen, data_sram_addr = ALU result, data_sram_wdata = rdata2.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when a div/divu (opcode 0, func 011010/011011) is in EX. On this edge, latch |rs|, |rt| (unsigned for divu) and the signs, and clear count.
  - BUSY: one restoring step per cycle, count 0..31. BUSY→DONE after count=31.
  - DONE→IDLE on an edge with stall[3]=NoStop. On that same edge HI<=remainder, LO<=quotient. Hold DONE while stall[3]=Stop.
  - Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: LO=32'hFFFF_FFFF, HI=rs, for both div and divu.
- stallreq_for_ex = div in EX and state≠DONE (IDLE or BUSY), combinational.
- rst: FSM to IDLE, count 0, HI=LO=0, regardless of state.

## Timing
- Reset values:
  - All outputs are 0, since the input register is cleared.
  - stallreq_for_ex is 0.
- Single-cycle ops: result is valid the cycle after the bundle is loaded, purely combinational from the EX register.
- ex_to_rf_bus mirrors ex_to_mem_bus fields in the same cycle.
- div/divu with no downstream stall:
  - stallreq_for_ex is high for 33 consecutive cycles: 1 IDLE cycle plus 32 BUSY cycles.
  - The 34th cycle is DONE with stallreq_for_ex low.
  - HI/LO become visible to the next instruction's mfhi/mflo in its first EX cycle.
- mthi followed immediately by mfhi returns the new value.
- Bubble cycles (cleared register) never write HI/LO and never start the divider.

## Test plan
- addiu rt←rs+imm, rs=32'h7FFF_FFFF, imm=16'h0001 → ex_result=32'h8000_0000, rf_we=1, waddr=rt, data_sram_en=0.
- lui imm=16'h1234 → ex_result=32'h1234_0000; sw with rs=32'h1000, imm=16'hFFFC, rt=32'hAABB_CCDD → data_sram_addr=32'h0FFC, wen=4'hF, wdata=32'hAABB_CCDD.
- div rs=-7, rt=2, then mflo, mfhi:
  - stallreq_for_ex high exactly 33 cycles.
  - mflo → 32'hFFFF_FFFD, mfhi → 32'hFFFF_FFFF.
- divu rs=32'h0000_0005, rt=0 → LO=32'hFFFF_FFFF, HI=32'h5; hold stall[3]=Stop for 3 cycles in DONE → HI/LO unchanged until release.
- rst asserted in BUSY count=10 → next cycle state IDLE, HI=LO=0, all outputs 0, stallreq_for_ex=0.
- stall=6'b000111 with a valid add pending → EX register cleared; next cycle rf_we=0, ram_en=0; HI/LO unchanged.
